// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifu_pkg
// Brief   : Shared types and constants for the instruction fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
package ifu_pkg;

    localparam int          IFU_ADDR_W       = 32;
    localparam int          IFU_INST_W       = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_OUT  = 3'd3,
        S_WAIT = 3'd4
    } ifu_state_e;

    // Instructions are word aligned; any set low bit is an alignment fault.
    function automatic logic pc_aligned(input logic [1:0] pc_lsb);
        return (pc_lsb == 2'b00);
    endfunction

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_if.sv
`default_nettype none
// ============================================================================
// Module  : ifu_if
// Brief   : Instruction memory request/response bus (valid/ready both ways).
// Revision: 1.0 - initial release
// ============================================================================
interface ifu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] rdata;
    logic              resp_err;

    modport master (
        output req_valid, addr, resp_ready,
        input  req_ready, resp_valid, rdata, resp_err
    );

    modport slave (
        input  req_valid, addr, resp_ready,
        output req_ready, resp_valid, rdata, resp_err
    );
endinterface : ifu_if
`default_nettype wire

// File: rtl/ifu_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module  : ifu_perf_cnt
// Brief   : Fetch and stall event counters, 64-bit wrapping. Built only when
//           IFU_PERF_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`ifdef IFU_PERF_EN
module ifu_perf_cnt (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        fetch_inc_i,
    input  wire logic        stall_inc_i,
    output logic      [63:0] fetch_cnt_o,
    output logic      [63:0] stall_cnt_o
);
    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [63:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {63'd0, fetch_inc_i};
        stall_cnt_d = stall_cnt_q + {63'd0, stall_inc_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
endmodule : ifu_perf_cnt
`endif
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module  : ifu
// Brief   : Multi-cycle instruction fetch: one imem fetch per instruction,
//           handed to idu, then waits for dnpc. Optional perf counters under
//           IFU_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ifu
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter int                DATA_W   = IFU_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    ifu_if.master                  imem,
    output logic                   inst_valid,
    input  wire logic              inst_ready,
    output logic      [DATA_W-1:0] inst,
    output logic      [ADDR_W-1:0] inst_pc,
    output logic                   inst_fault,
    input  wire logic              dnpc_valid,
    input  wire logic [ADDR_W-1:0] dnpc,
    output logic      [63:0]       perf_fetch_cnt,
    output logic      [63:0]       perf_stall_cnt
);
    ifu_state_e        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] inst_q;
    logic              fault_q;
    logic              req_valid_q;
    logic              resp_ready_q;
    logic              inst_valid_q;

    // All handshake outputs come straight from flops so no ready feeds a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            fault_q      <= 1'b0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    req_valid_q <= pc_aligned(pc_q[1:0]);
                    state_q     <= S_REQ;
                end
                S_REQ: begin
                    if (!pc_aligned(pc_q[1:0])) begin
                        inst_q       <= '0;
                        fault_q      <= 1'b1;
                        req_valid_q  <= 1'b0;
                        inst_valid_q <= 1'b1;
                        state_q      <= S_OUT;
                    end else if (imem.req_ready) begin
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (imem.resp_valid) begin
                        inst_q       <= imem.resp_err ? '0 : imem.rdata;
                        fault_q      <= imem.resp_err;
                        resp_ready_q <= 1'b0;
                        inst_valid_q <= 1'b1;
                        state_q      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dnpc_valid) begin
                        pc_q        <= dnpc;
                        req_valid_q <= pc_aligned(dnpc[1:0]);
                        state_q     <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem.req_valid  = req_valid_q;
    assign imem.addr       = pc_q;
    assign imem.resp_ready = resp_ready_q;
    assign inst_valid      = inst_valid_q;
    assign inst            = inst_q;
    assign inst_pc         = pc_q;
    assign inst_fault      = fault_q;

`ifdef IFU_PERF_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = inst_valid_q & inst_ready;
    assign stall_inc = (state_q == S_REQ) || (state_q == S_RESP);

    ifu_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_inc_i (fetch_inc),
        .stall_inc_i (stall_inc),
        .fetch_cnt_o (perf_fetch_cnt),
        .stall_cnt_o (perf_stall_cnt)
    );
`else
    assign perf_fetch_cnt = 64'd0;
    assign perf_stall_cnt = 64'd0;
`endif

    // Upstream protocol errors: such inputs are ignored by the FSM above.
    a_dnpc_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        dnpc_valid |-> (state_q == S_WAIT));
    a_resp_only_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
        imem.resp_valid |-> (state_q == S_RESP));

endmodule : ifu
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifu
// Brief   : Directed self-checking bench for the instruction fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifu;
    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        dnpc_valid;
    logic [31:0] dnpc;
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_hs    = 0;

    ifu_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();

    ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus.master),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .dnpc_valid     (dnpc_valid),
        .dnpc           (dnpc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [63:0] perf_exp(input logic [63:0] v);
`ifdef IFU_PERF_EN
        return v;
`else
        return (v & 64'd0);
`endif
    endfunction

    // Wait for a request, optionally stall it, accept it, return one response.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input logic err, input int hold);
        int n = 0;
        while (!imem_bus.req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", imem_bus.req_valid, 1);
        chk("req_addr", imem_bus.addr, addr);
        for (int i = 0; i < hold; i++) begin
            imem_bus.req_ready = 1'b0;
            @(negedge clk);
            chk("req_hold_valid", imem_bus.req_valid, 1);
            chk("req_hold_addr", imem_bus.addr, addr);
        end
        imem_bus.req_ready = 1'b1;
        @(negedge clk);
        imem_bus.req_ready = 1'b0;
        chk("req_dropped", imem_bus.req_valid, 0);
        chk("resp_ready", imem_bus.resp_ready, 1);
        imem_bus.resp_valid = 1'b1;
        imem_bus.rdata      = data;
        imem_bus.resp_err   = err;
        @(negedge clk);
        imem_bus.resp_valid = 1'b0;
        imem_bus.rdata      = '0;
        imem_bus.resp_err   = 1'b0;
    endtask

    task automatic chk_inst(input logic [31:0] exp_inst, input logic [31:0] exp_pc,
                            input logic exp_fault);
        chk("inst_valid", inst_valid, 1);
        chk("inst", inst, exp_inst);
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_fault", inst_fault, exp_fault);
    endtask

    task automatic accept(input logic [31:0] exp_inst, input int stall);
        for (int i = 0; i < stall; i++) begin
            inst_ready = 1'b0;
            @(negedge clk);
            chk("inst_hold_valid", inst_valid, 1);
            chk("inst_hold_data", inst, exp_inst);
            chk("no_req_in_out", imem_bus.req_valid, 0);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        n_hs++;
        chk("inst_valid_drop", inst_valid, 0);
        chk("perf_fetch", perf_fetch_cnt, perf_exp(64'(n_hs)));
    endtask

    task automatic send_dnpc(input logic [31:0] pc);
        dnpc_valid = 1'b1;
        dnpc       = pc;
        @(negedge clk);
        dnpc_valid = 1'b0;
        dnpc       = '0;
        chk("dnpc_req_valid", imem_bus.req_valid, (pc[1:0] == 2'b00));
        chk("dnpc_addr", imem_bus.addr, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n               = 1'b0;
        inst_ready          = 1'b0;
        dnpc_valid          = 1'b0;
        dnpc                = '0;
        imem_bus.req_ready  = 1'b0;
        imem_bus.resp_valid = 1'b0;
        imem_bus.rdata      = '0;
        imem_bus.resp_err   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req_valid", imem_bus.req_valid, 0);
        chk("rst_resp_ready", imem_bus.resp_ready, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_fault", inst_fault, 0);
        chk("rst_addr", imem_bus.addr, 32'h8000_0000);
        chk("rst_perf_fetch", perf_fetch_cnt, 0);
        chk("rst_perf_stall", perf_stall_cnt, 0);
        rst_n = 1'b1;

        // 1: first fetch after reset, immediate accept and 1-cycle response
        do_fetch(32'h8000_0000, 32'h0000_0013, 1'b0, 0);
        chk_inst(32'h0000_0013, 32'h8000_0000, 1'b0);
        chk("perf_stall_first", perf_stall_cnt, perf_exp(64'd2));
        accept(32'h0000_0013, 0);
        send_dnpc(32'h8000_0004);

        // 2: request back-pressured for 3 cycles
        do_fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 3);
        chk_inst(32'h0010_0093, 32'h8000_0004, 1'b0);
        accept(32'h0010_0093, 0);
        send_dnpc(32'h8000_0008);

        // 3: idu back-pressure for 5 cycles, then no fetch until dnpc
        do_fetch(32'h8000_0008, 32'h0020_8133, 1'b0, 0);
        chk_inst(32'h0020_8133, 32'h8000_0008, 1'b0);
        accept(32'h0020_8133, 5);
        repeat (2) begin
            @(negedge clk);
            chk("wait_no_req", imem_bus.req_valid, 0);
        end

        // 4: misaligned PC faults without touching imem
        send_dnpc(32'h8000_0102);
        @(negedge clk);
        chk("misalign_no_req", imem_bus.req_valid, 0);
        chk_inst(32'h0000_0000, 32'h8000_0102, 1'b1);
        accept(32'h0000_0000, 0);
        send_dnpc(32'h8000_0010);

        // 5: access fault, then normal fetch
        do_fetch(32'h8000_0010, 32'hdead_beef, 1'b1, 0);
        chk_inst(32'h0000_0000, 32'h8000_0010, 1'b1);
        accept(32'h0000_0000, 0);
        send_dnpc(32'h8000_0014);
        do_fetch(32'h8000_0014, 32'h0000_0513, 1'b0, 0);
        chk_inst(32'h0000_0513, 32'h8000_0014, 1'b0);
        accept(32'h0000_0513, 0);
        send_dnpc(32'h8000_0020);

        // 6: async reset while waiting for a response
        imem_bus.req_ready = 1'b1;
        @(negedge clk);
        imem_bus.req_ready = 1'b0;
        chk("pre_rst_resp_ready", imem_bus.resp_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", imem_bus.req_valid, 0);
        chk("arst_resp_ready", imem_bus.resp_ready, 0);
        chk("arst_inst_valid", inst_valid, 0);
        chk("arst_inst", inst, 0);
        chk("arst_fault", inst_fault, 0);
        chk("arst_perf_fetch", perf_fetch_cnt, 0);
        chk("arst_addr", imem_bus.addr, 32'h8000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        n_hs  = 0;
        do_fetch(32'h8000_0000, 32'h0000_0013, 1'b0, 0);
        chk_inst(32'h0000_0013, 32'h8000_0000, 1'b0);
        accept(32'h0000_0013, 0);
        send_dnpc(32'h8000_0004);
        do_fetch(32'h8000_0004, 32'h0041_0113, 1'b0, 0);
        chk_inst(32'h0041_0113, 32'h8000_0004, 1'b0);
        accept(32'h0041_0113, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule : tb_ifu
`default_nettype wire
